// File: rtl/seven_segment_scan_driver.sv
// rtl/seven_segment_scan_driver.sv - multiplexed 7-segment scan driver; SEG_HEX_EN enables A-F glyphs
module seven_segment_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int BLANK_CYC  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_en,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   dig_sel_n,
   output logic                    frame_tick,
   output logic                    pending
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] shadow_dig;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [4*NUM_DIGITS-1:0] disp_dig;
   logic [NUM_DIGITS-1:0]   disp_dp;

   logic                    frame_wrap;
   logic                    in_blank;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_lz;
   logic [NUM_DIGITS-1:0]   sel_n;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'h3F;
         4'h1: decode = 7'h06;
         4'h2: decode = 7'h5B;
         4'h3: decode = 7'h4F;
         4'h4: decode = 7'h66;
         4'h5: decode = 7'h6D;
         4'h6: decode = 7'h7D;
         4'h7: decode = 7'h07;
         4'h8: decode = 7'h7F;
         4'h9: decode = 7'h6F;
`ifdef SEG_HEX_EN
         4'hA: decode = 7'h77;
         4'hB: decode = 7'h7C;
         4'hC: decode = 7'h39;
         4'hD: decode = 7'h5E;
         4'hE: decode = 7'h79;
         4'hF: decode = 7'h71;
`endif
         default: decode = 7'h00;
      endcase
   endfunction

   assign frame_wrap = en && (presc == PRESC_LAST) && (idx == IDX_LAST);
   assign in_blank   = (presc < BLANK_END);

   // Pick the current digit's nibble/dp/select and decide leading-zero blanking top-down
   always_comb begin
      logic run_zero;
      run_zero = 1'b1;
      cur_nib  = 4'h0;
      cur_dp   = 1'b0;
      cur_lz   = 1'b0;
      sel_n    = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run_zero = run_zero && (disp_dig[4*i +: 4] == 4'h0);
         if (idx == IW'(i)) begin
            cur_nib  = disp_dig[4*i +: 4];
            cur_dp   = disp_dp[i];
            cur_lz   = lz_en && run_zero && (i != 0);
            sel_n[i] = 1'b0;
         end
      end
   end

   // Scan timing, double buffer and frame commit
   always_ff @(posedge clk) begin
      if (rst) begin
         presc      <= '0;
         idx        <= '0;
         frame_tick <= 1'b0;
         pending    <= 1'b0;
         shadow_dig <= '0;
         shadow_dp  <= '0;
         disp_dig   <= '0;
         disp_dp    <= '0;
      end else begin
         if (!en) begin
            presc <= '0;
            idx   <= '0;
         end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
         frame_tick <= frame_wrap;
         // Commit uses the shadow as it was before any same-edge load
         if (frame_wrap && pending) begin
            disp_dig <= shadow_dig;
            disp_dp  <= shadow_dp;
         end
         if (load) begin
            shadow_dig <= digits_in;
            shadow_dp  <= dp_in;
            pending    <= 1'b1;
         end else if (frame_wrap) begin
            pending    <= 1'b0;
         end
      end
   end

   // Registered pin drive: blank gap at slot start, forced off while disabled
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_out   <= 8'h00;
         dig_sel_n <= '1;
      end else if (!en || in_blank) begin
         seg_out   <= 8'h00;
         dig_sel_n <= '1;
      end else begin
         seg_out   <= {cur_dp, cur_lz ? 7'h00 : decode(cur_nib)};
         dig_sel_n <= sel_n;
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb/tb_seven_segment_scan_driver.sv - directed bench for seven_segment_scan_driver
module tb_seven_segment_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        lz_en;
   logic [7:0]  seg_out;
   logic [3:0]  dig_sel_n;
   logic        frame_tick;
   logic        pending;

   int compared   = 0;
   int mismatched = 0;
   int n;

`ifdef SEG_HEX_EN
   localparam logic [31:0] HEX_FRAME = {8'h77, 8'h7C, 8'h39, 8'h71};
   localparam logic [7:0]  HEX_D0    = 8'h71;
`else
   localparam logic [31:0] HEX_FRAME = 32'h0;
   localparam logic [7:0]  HEX_D0    = 8'h00;
`endif

   seven_segment_scan_driver #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4),
      .BLANK_CYC  (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .lz_en      (lz_en),
      .seg_out    (seg_out),
      .dig_sel_n  (dig_sel_n),
      .frame_tick (frame_tick),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [15:0] d, input logic [3:0] p);
      digits_in = d;
      dp_in     = p;
      load      = 1'b1;
      step();
      load      = 1'b0;
   endtask

   task automatic wait_wrap(output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!frame_tick && cnt < 64);
   endtask

   // Called right after a frame_tick sample; walks one full frame (segs = {d3,d2,d1,d0})
   task automatic check_frame(input string tag, input logic [31:0] segs);
      logic [7:0] es;
      logic [3:0] ed;
      int d;
      for (int k = 1; k <= 16; k++) begin
         step();
         d = (k - 1) / 4;
         if (((k - 1) % 4) == 0) begin
            es = 8'h00;
            ed = 4'hF;
         end else begin
            es = segs[8*d +: 8];
            ed = ~(4'b0001 << d);
         end
         chk($sformatf("%s_k%0d_seg", tag, k), {24'h0, seg_out}, {24'h0, es});
         chk($sformatf("%s_k%0d_sel", tag, k), {28'h0, dig_sel_n}, {28'h0, ed});
         chk($sformatf("%s_k%0d_tick", tag, k), {31'h0, frame_tick}, (k == 16) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; load = 1'b0; lz_en = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
      step();
      step();
      chk("rst_seg", {24'h0, seg_out}, 32'h00);
      chk("rst_sel", {28'h0, dig_sel_n}, 32'hF);
      chk("rst_tick", {31'h0, frame_tick}, 32'd0);
      chk("rst_pending", {31'h0, pending}, 32'd0);

      rst = 1'b0;
      load_word(16'h1234, 4'b0100);
      chk("load1_pending", {31'h0, pending}, 32'd1);
      wait_wrap(n);
      chk("wrap1_latency", n, 15);
      chk("wrap1_pending", {31'h0, pending}, 32'd0);
      check_frame("f1234", {8'h06, 8'hDB, 8'h4F, 8'h66});

      step(); step();
      load_word(16'h5678, 4'b1111);
      step();
      load_word(16'h9999, 4'b0000);
      chk("lastwins_pending", {31'h0, pending}, 32'd1);
      wait_wrap(n);
      chk("lastwins_latency", n, 11);
      check_frame("f9999", {8'h6F, 8'h6F, 8'h6F, 8'h6F});

      step(); step();
      load_word(16'h8086, 4'b0001);
      for (int i = 0; i < 12; i++) step();
      load_word(16'h2525, 4'b0000);
      chk("sameedge_tick", {31'h0, frame_tick}, 32'd1);
      chk("sameedge_pending", {31'h0, pending}, 32'd1);
      check_frame("f8086", {8'h7F, 8'h3F, 8'h7F, 8'hFD});
      chk("sameedge_commit_pending", {31'h0, pending}, 32'd0);
      check_frame("f2525", {8'h5B, 8'h6D, 8'h5B, 8'h6D});

      lz_en = 1'b1;
      load_word(16'h0070, 4'b0000);
      wait_wrap(n);
      chk("lz1_latency", n, 15);
      check_frame("lz0070", {8'h00, 8'h00, 8'h07, 8'h3F});
      load_word(16'h0000, 4'b1000);
      wait_wrap(n);
      chk("lz2_latency", n, 15);
      check_frame("lz0000", {8'h80, 8'h00, 8'h00, 8'h3F});
      lz_en = 1'b0;

      load_word(16'hABCF, 4'b0000);
      wait_wrap(n);
      chk("hex_latency", n, 15);
      check_frame("hexABCF", HEX_FRAME);

      for (int i = 0; i < 9; i++) step();
      en = 1'b0;
      step();
      chk("endrop_seg", {24'h0, seg_out}, 32'h00);
      chk("endrop_sel", {28'h0, dig_sel_n}, 32'hF);
      load_word(16'h1234, 4'b0100);
      chk("endrop_load_pending", {31'h0, pending}, 32'd1);
      step();
      chk("endrop_hold_sel", {28'h0, dig_sel_n}, 32'hF);
      chk("endrop_hold_tick", {31'h0, frame_tick}, 32'd0);
      en = 1'b1;
      step();
      chk("resume_blank_seg", {24'h0, seg_out}, 32'h00);
      chk("resume_blank_sel", {28'h0, dig_sel_n}, 32'hF);
      step();
      chk("resume_d0_sel", {28'h0, dig_sel_n}, 32'hE);
      chk("resume_d0_seg", {24'h0, seg_out}, {24'h0, HEX_D0});
      wait_wrap(n);
      chk("resume_latency", n, 14);
      check_frame("resume1234", {8'h06, 8'hDB, 8'h4F, 8'h66});

      for (int i = 0; i < 5; i++) step();
      load_word(16'h5555, 4'b1111);
      chk("prerst_pending", {31'h0, pending}, 32'd1);
      rst = 1'b1;
      step();
      chk("midrst_seg", {24'h0, seg_out}, 32'h00);
      chk("midrst_sel", {28'h0, dig_sel_n}, 32'hF);
      chk("midrst_tick", {31'h0, frame_tick}, 32'd0);
      chk("midrst_pending", {31'h0, pending}, 32'd0);
      rst = 1'b0;
      wait_wrap(n);
      chk("postrst_latency", n, 16);
      chk("postrst_pending", {31'h0, pending}, 32'd0);
      check_frame("postrst", {8'h3F, 8'h3F, 8'h3F, 8'h3F});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
